// File: rtl/coin_pkg.sv
// Shared coin definitions: coin values, one-hot deposit codes, output FSM
// state encodings and the record format. The vending FSM imports these too.
package coin_pkg;

  // Coin values in cents; 6 bits is enough because the largest value is 25.
  localparam logic [5:0] COIN_5_VAL  = 6'd5;
  localparam logic [5:0] COIN_10_VAL = 6'd10;
  localparam logic [5:0] COIN_25_VAL = 6'd25;

  // One-hot deposit codes, bit order {25,10,5}.
  localparam logic [2:0] CODE_5  = 3'b001;
  localparam logic [2:0] CODE_10 = 3'b010;
  localparam logic [2:0] CODE_25 = 3'b100;

  // Output FSM states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // One deposit record as presented to the consumer.
  typedef struct packed {
    logic [2:0] code;
    logic [5:0] val;
  } deposit_t;

  // True when coin events are present on two or more channels at once.
  function automatic logic multi_event(input logic [2:0] ev);
    return (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  endfunction

  // Record for exactly one event; all-zero for no event or for a jam.
  function automatic deposit_t decode_event(input logic [2:0] ev);
    deposit_t rec;
    rec = '0;
    case (ev)
      CODE_5:  begin rec.code = CODE_5;  rec.val = COIN_5_VAL;  end
      CODE_10: begin rec.code = CODE_10; rec.val = COIN_10_VAL; end
      CODE_25: begin rec.code = CODE_25; rec.val = COIN_25_VAL; end
      default: rec = '0;
    endcase
    return rec;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchroniser, consecutive-sample debouncer and a
// one-cycle event on every 0->1 change of the debounced level.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic coin_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q,   rise_d;

  // Next-state: count disagreeing samples; flip the stable level once the
  // disagreement has lasted DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
        rise_d   = ~stable_q;   // only the 0->1 change is a coin event
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, matching the hardware.
    if (RST) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= coin_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin input front end: three debounced channels, same-cycle jam detection,
// and a one-deep deposit record behind a valid/ready handshake.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       coin_25,
  input  logic       dep_ready,
  output logic       dep_valid,
  output logic [2:0] dep_code,
  output logic [5:0] dep_val,
  output logic       jam,
  output logic       overrun
);

  logic [2:0] ev;        // {25,10,5} one-cycle coin events
  logic       single_ev;
  logic       multi_ev;

  logic [0:0] state_q,   state_d;
  deposit_t   rec_q,     rec_d;
  logic       jam_q,     jam_d;
  logic       overrun_q, overrun_d;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_5 (
    .CLK    (CLK),
    .RST    (RST),
    .coin_i (coin_5),
    .rise_o (ev[0])
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_10 (
    .CLK    (CLK),
    .RST    (RST),
    .coin_i (coin_10),
    .rise_o (ev[1])
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_25 (
    .CLK    (CLK),
    .RST    (RST),
    .coin_i (coin_25),
    .rise_o (ev[2])
  );

  assign multi_ev  = multi_event(ev);
  assign single_ev = (ev != 3'b000) && !multi_ev;

  // Output FSM: load a single event in IDLE; in PEND either hand over
  // (possibly reloading in the same cycle) or flag a dropped event.
  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    overrun_d = overrun_q;
    jam_d     = multi_ev;   // jams are reported in every state
    case (state_q)
      ST_IDLE: begin
        if (single_ev) begin
          rec_d   = decode_event(ev);
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (dep_ready) begin
          if (single_ev) begin
            rec_d = decode_event(ev);
          end else begin
            rec_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (single_ev) begin
          overrun_d = 1'b1;     // record is kept; the new coin is lost
        end
      end
      default: begin
        rec_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, record, jam pulse and sticky overrun registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      rec_q     <= '0;
      jam_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_q     <= rec_d;
      jam_q     <= jam_d;
      overrun_q <= overrun_d;
    end
  end

  assign dep_valid = (state_q == ST_PEND);
  assign dep_code  = rec_q.code;
  assign dep_val   = rec_q.val;
  assign jam       = jam_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner at DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_coin_input_conditioner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       coin_5, coin_10, coin_25;
  logic       dep_ready;
  logic       dep_valid;
  logic [2:0] dep_code;
  logic [5:0] dep_val;
  logic       jam;
  logic       overrun;

  int         checks   = 0;
  int         failures = 0;
  int         valid_cycles;
  int         jam_cycles;
  int         drops;
  logic [5:0] last_val;
  logic [2:0] last_code;

  always #5 CLK = ~CLK;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .coin_5    (coin_5),
    .coin_10   (coin_10),
    .coin_25   (coin_25),
    .dep_ready (dep_ready),
    .dep_valid (dep_valid),
    .dep_code  (dep_code),
    .dep_val   (dep_val),
    .jam       (jam),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts();
    valid_cycles = 0;
    jam_cycles   = 0;
    last_val     = '0;
    last_code    = '0;
  endtask

  // Advance n cycles, tallying valid cycles, jam cycles and the last record seen.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (dep_valid === 1'b1) begin
        valid_cycles++;
        last_val  = dep_val;
        last_code = dep_code;
      end
      if (jam === 1'b1) jam_cycles++;
    end
  endtask

  initial begin
    RST = 1'b1; coin_5 = 1'b0; coin_10 = 1'b0; coin_25 = 1'b0; dep_ready = 1'b0;
    repeat (3) step();
    check("rst_valid",   dep_valid, 0);
    check("rst_code",    dep_code,  0);
    check("rst_val",     dep_val,   0);
    check("rst_jam",     jam,       0);
    check("rst_overrun", overrun,   0);
    RST = 1'b0;
    step();

    // 1: coin_10 held 20 cycles, consumer always ready -> one record, latency 6
    dep_ready = 1'b1;
    coin_10   = 1'b1;
    repeat (6) step();
    check("t1_before_edge6", dep_valid, 0);
    step();
    check("t1_valid", dep_valid, 1);
    check("t1_code",  dep_code,  3'b010);
    check("t1_val",   dep_val,   10);
    step();
    check("t1_acked", dep_valid, 0);
    check("t1_code0", dep_code,  0);
    clear_counts();
    run(12);
    coin_10 = 1'b0;
    run(10);
    check("t1_no_repeat", valid_cycles, 0);

    // 2: 3-cycle glitch gives nothing; bounce then hold gives exactly one 5
    clear_counts();
    coin_5 = 1'b1; run(3);
    coin_5 = 1'b0; run(12);
    check("t2_glitch", valid_cycles, 0);
    clear_counts();
    for (int b = 0; b < 3; b++) begin
      coin_5 = 1'b1; run(2);
      coin_5 = 1'b0; run(2);
    end
    coin_5 = 1'b1; run(10);
    coin_5 = 1'b0; run(10);
    check("t2_bounce_count", valid_cycles, 1);
    check("t2_bounce_val",   last_val,     5);
    check("t2_bounce_code",  last_code,    3'b001);

    // 3: pending 25 with no ack, then a 5 arrives -> overrun, record intact
    dep_ready = 1'b0;
    coin_25   = 1'b1; run(8);
    coin_25   = 1'b0;
    check("t3_valid", dep_valid, 1);
    check("t3_val",   dep_val,   25);
    check("t3_code",  dep_code,  3'b100);
    run(8);
    check("t3_held",       dep_val, 25);
    check("t3_no_overrun", overrun, 0);
    coin_5 = 1'b1; run(8);
    coin_5 = 1'b0; run(8);
    check("t3_overrun",    overrun,   1);
    check("t3_keep_val",   dep_val,   25);
    check("t3_keep_valid", dep_valid, 1);
    dep_ready = 1'b1;
    step();
    check("t3_ack_valid",   dep_valid, 0);
    check("t3_ack_val",     dep_val,   0);
    check("t3_overrun_sticky", overrun, 1);

    // 4: coin_5 and coin_10 together -> one jam cycle, no deposit
    clear_counts();
    coin_5 = 1'b1; coin_10 = 1'b1; run(12);
    coin_5 = 1'b0; coin_10 = 1'b0; run(10);
    check("t4_jam_cycles", jam_cycles,   1);
    check("t4_no_deposit", valid_cycles, 0);
    check("t4_overrun",    overrun,      1);

    // 5: reset while pending, with coin_25 held across reset release
    dep_ready = 1'b0;
    coin_10   = 1'b1; run(8);
    coin_10   = 1'b0;
    check("t5_pend_val", dep_val, 10);
    run(8);
    coin_25 = 1'b1;
    RST     = 1'b1;
    step();
    check("t5_rst_valid",   dep_valid, 0);
    check("t5_rst_overrun", overrun,   0);
    check("t5_rst_val",     dep_val,   0);
    step();
    RST = 1'b0;
    repeat (6) step();
    check("t5_before_edge6", dep_valid, 0);
    step();
    check("t5_valid", dep_valid, 1);
    check("t5_val",   dep_val,   25);
    dep_ready = 1'b1;
    step();
    check("t5_acked", dep_valid, 0);
    dep_ready = 1'b0;
    coin_25   = 1'b0;
    run(10);

    // 6: 10 pending, 25 event coincides with the ack -> back-to-back records
    coin_10 = 1'b1;
    repeat (7) step();
    check("t6_first_valid", dep_valid, 1);
    check("t6_first_val",   dep_val,   10);
    coin_10 = 1'b0;
    coin_25 = 1'b1;
    drops   = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dep_valid !== 1'b1 || dep_val !== 6'd10) drops++;
    end
    dep_ready = 1'b1;
    step();
    check("t6_first_held", drops,     0);
    check("t6_second_valid", dep_valid, 1);
    check("t6_second_val",   dep_val,   25);
    check("t6_second_code",  dep_code,  3'b100);
    step();
    check("t6_second_acked", dep_valid, 0);
    check("t6_no_overrun",   overrun,   0);
    dep_ready = 1'b0;
    coin_25   = 1'b0;
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
